if_fetch_aligner: RTL

//  Producer side of the icache->pre_if interface. Issues word-aligned fetch requests to the

---
 rtl/if_pkg.sv | 14 +
 rtl/if_hword_buffer.sv | 85 ++++++++
 rtl/if_fetch_aligner.sv | 130 +++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the fetch aligner:
// FSM encoding, instruction-length marker, default reset PC.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [1:0]  INST_LEN32   = 2'b11;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

endpackage

// File: rtl/if_hword_buffer.sv
// Circular halfword FIFO: one/two-halfword push and pop,
// synchronous clear, and a peek of the two oldest entries.
module if_hword_buffer
  import if_pkg::*;
#(
  parameter  int BUF_HW = 4,
  localparam int CW     = $clog2(BUF_HW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push1,
  input  logic          push2,
  input  logic [31:0]   push_data,
  input  logic          pop1,
  input  logic          pop2,
  output logic [CW-1:0] count_o,
  output logic [15:0]   hw0_o,
  output logic [15:0]   hw1_o
);

  localparam int PW = $clog2(BUF_HW);

  logic [15:0]   mem_q [BUF_HW];
  logic [15:0]   mem_d [BUF_HW];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    n_push, n_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input logic [1:0]    n
  );
    int unsigned s;
    s = 32'(p) + 32'(n);
    if (s >= 32'(BUF_HW)) s = s - 32'(BUF_HW);
    return PW'(s);
  endfunction

  assign n_push = {push2, push1 && !push2};
  assign n_pop  = {pop2, pop1 && !pop2};

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push2) begin
        mem_d[wr_q]          = push_data[15:0];
        mem_d[wrap(wr_q, 1)] = push_data[31:16];
      end else if (push1) begin
        mem_d[wr_q] = push_data[31:16];
      end
      rd_d  = wrap(rd_q, n_pop);
      wr_d  = wrap(wr_q, n_push);
      cnt_d = cnt_q + CW'(n_push) - CW'(n_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign hw0_o   = mem_q[rd_q];
  assign hw1_o   = mem_q[wrap(rd_q, 1)];

endmodule

// File: rtl/if_fetch_aligner.sv
// Fetch request FSM plus halfword realignment: turns
// word-aligned icache returns into one RV32IC instruction per handshake.
module if_fetch_aligner
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_rvalid_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int CW = $clog2(BUF_HW + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   next_addr_q, next_addr_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          skip_q, skip_d;
  logic [CW-1:0] cnt, cnt_after;
  logic [15:0]   hw0, hw1;
  logic [1:0]    n_pop;
  logic          head16, xfer, pop1, pop2;
  logic          push1, push2;
  logic          unused_pc_bit0;

  assign unused_pc_bit0 = redirect_pc_i[0];

  if_hword_buffer #(
    .BUF_HW(BUF_HW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush_i),
    .push1    (push1),
    .push2    (push2),
    .push_data(fetch_rdata_i),
    .pop1     (pop1),
    .pop2     (pop2),
    .count_o  (cnt),
    .hw0_o    (hw0),
    .hw1_o    (hw1)
  );

  assign head16       = hw0[1:0] != INST_LEN32;
  assign inst_valid_o = !flush_i
                        && ((cnt != '0 && head16)
                            || cnt >= CW'(2));
  assign xfer         = inst_valid_o && inst_ready_i;
  assign pop1         = xfer && head16;
  assign pop2         = xfer && !head16;
  assign n_pop        = {pop2, pop1};
  assign cnt_after    = cnt - CW'(n_pop);

  assign inst_o       = head16 ? {16'b0, hw0} : {hw1, hw0};
  assign inst_addr_o  = head_pc_q;
  assign fetch_req_o  = state_q != IDLE;
  assign fetch_addr_o = addr_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    head_pc_d   = head_pc_q;
    skip_d      = skip_q;
    push1       = 1'b0;
    push2       = 1'b0;

    if (xfer)
      head_pc_d = head_pc_q + (head16 ? 32'd2 : 32'd4);

    unique case (state_q)
      IDLE: begin
        // Reserve room for a full word before asking.
        if (!flush_i && cnt_after <= CW'(BUF_HW - 2)) begin
          state_d = WAIT;
          addr_d  = next_addr_q;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = fetch_rvalid_i ? IDLE : DROP;
        end else if (fetch_rvalid_i) begin
          push2       = !skip_q;
          push1       = skip_q;
          skip_d      = 1'b0;
          next_addr_d = next_addr_q + 32'd4;
          state_d     = IDLE;
        end
      end
      DROP: begin
        if (fetch_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      head_pc_d   = {redirect_pc_i[31:1], 1'b0};
      next_addr_d = {redirect_pc_i[31:2], 2'b00};
      skip_d      = redirect_pc_i[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= RESET_PC;
      next_addr_q <= {RESET_PC[31:2], 2'b00};
      head_pc_q   <= RESET_PC;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      head_pc_q   <= head_pc_d;
      skip_q      <= skip_d;
    end
  end

endmodule
